// File: rtl/shift_seq_pkg.sv
// Shared types for the iterative barrel-shifter sequencer.
// Shift kinds, FSM states and the default per-cycle step.
package shift_seq_pkg;

  localparam int STEP_DEFAULT = 8;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Clamp the raw Rs[7:0] count to the number of single-bit steps
  // that still change the value or carry for each shift kind.
  function automatic logic [5:0] calc_count(
    input shift_t     t,
    input logic [7:0] amt
  );
    logic [5:0] n;
    case (t)
      SH_LSL, SH_LSR: n = (amt > 8'd33) ? 6'd33 : amt[5:0];
      SH_ASR:         n = (amt > 8'd32) ? 6'd32 : amt[5:0];
      SH_ROR:         n = {1'b0, amt[4:0]};
      default:        n = 6'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_seq_step.sv
// One shift of 0..STEP positions, built from single-bit stages.
// Carry tracks the last bit shifted out; k=0 passes through.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic [31:0] val_i,
  input  shift_t      type_i,
  input  logic [5:0]  k_i,
  input  logic        carry_i,
  output logic [31:0] val_o,
  output logic        carry_o
);

  // Apply up to STEP single-bit shifts, gated by the requested count.
  always_comb begin
    val_o   = val_i;
    carry_o = carry_i;
    for (int i = 0; i < STEP; i++) begin
      if (6'(i) < k_i) begin
        case (type_i)
          SH_LSL: begin
            carry_o = val_o[31];
            val_o   = {val_o[30:0], 1'b0};
          end
          SH_LSR: begin
            carry_o = val_o[0];
            val_o   = {1'b0, val_o[31:1]};
          end
          SH_ASR: begin
            carry_o = val_o[0];
            val_o   = {val_o[31], val_o[31:1]};
          end
          SH_ROR: begin
            carry_o = val_o[0];
            val_o   = {val_o[0], val_o[31:1]};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter for register-specified shift counts.
// Shifts at most STEP bits per cycle and pulses done at the end.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  amount,
  input  logic [31:0] operand,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_q, state_d;
  shift_t      type_q, type_d;
  logic [5:0]  rem_q, rem_d;
  logic [31:0] val_q, val_d;
  logic        c_q, c_d;

  logic [5:0]  k;
  logic [31:0] step_val;
  logic        step_c;
  shift_t      req_type;

  assign req_type = shift_t'(shift_type);
  assign k        = (rem_q > STEP_W) ? STEP_W : rem_q;

  shift_step #(.STEP(STEP)) u_step (
    .val_i   (val_q),
    .type_i  (type_q),
    .k_i     (k),
    .carry_i (c_q),
    .val_o   (step_val),
    .carry_o (step_c)
  );

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= SH_LSL;
      rem_q   <= '0;
      val_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      rem_q   <= rem_d;
      val_q   <= val_d;
      c_q     <= c_d;
    end
  end

  // Next-state: accept, iterate, finish; flush overrides all.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    rem_d   = rem_q;
    val_d   = val_q;
    c_d     = c_q;
    if (flush) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            type_d = req_type;
            val_d  = operand;
            c_d    = carry_in;
            if (amount == 8'd0) begin
              rem_d   = '0;
              state_d = S_DONE;
            end else if (req_type == SH_ROR &&
                         amount[4:0] == 5'd0) begin
              c_d     = operand[31];
              rem_d   = '0;
              state_d = S_DONE;
            end else begin
              rem_d   = calc_count(req_type, amount);
              state_d = S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          val_d = step_val;
          c_d   = step_c;
          rem_d = rem_q - k;
          if (rem_q == k) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign result    = val_q;
  assign carry_out = c_q;

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The module SHALL have the parameter STEP, default 8, giving the maximum bit positions shifted per cycle (legal values 1, 2, 4, 8).
REQ-002 The module SHALL have the port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have the port rst  input  1  reset, asynchronous, active-high.
REQ-004 The module SHALL have the port start  input  1  request to begin a register-specified shift; sampled only in IDLE.
REQ-005 The module SHALL have the port flush  input  1  synchronous abort; returns to IDLE, no done.
REQ-006 The module SHALL have the port shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-007 The module SHALL have the port amount  input  8  shift count, taken from Rs[7:0].
REQ-008 The module SHALL have the port operand  input  32  Rm value to shift.
REQ-009 The module SHALL have the port carry_in  input  1  current C flag.
REQ-010 The module SHALL have the port busy  output  1  high in SHIFT and DONE; the pipeline stalls on it.
REQ-011 The module SHALL have the port done  output  1  one-cycle pulse; result and carry_out are valid.
REQ-012 The module SHALL have the port result  output  32  shifted value (val2).
REQ-013 The module SHALL have the port carry_out  output  1  shifter carry-out.

Function
REQ-014 The module SHALL implement a state machine with the states IDLE, SHIFT and DONE.
REQ-015 On start in IDLE, the module SHALL latch operand, shift_type and carry_in, and SHALL compute the count n as follows: LSL/LSR n=min(amount,33); ASR n=min(amount,32); ROR n=amount[4:0].
REQ-016 When amount==0, the module SHALL go IDLE->DONE with result=operand and carry_out=carry_in.
REQ-017 For ROR with amount!=0 and amount[4:0]==0, the module SHALL go IDLE->DONE with result=operand and carry_out=operand[31].
REQ-018 Otherwise, the module SHALL go IDLE->SHIFT; each SHIFT cycle SHALL shift by k=min(remaining,STEP), set carry to the last bit shifted out and decrement remaining by k.
REQ-019 In SHIFT, the module SHALL zero-fill for LSL/LSR, sign-fill for ASR and wrap bits for ROR.
REQ-020 SHIFT SHALL go to DONE in the cycle after remaining reaches 0, so that done is asserted exactly ceil(n/STEP)+1 cycles after the start edge (1 cycle for the REQ-016/017 cases).
REQ-021 DONE SHALL last exactly one cycle, asserting done=1, and SHALL then return to IDLE.
REQ-022 result and carry_out SHALL hold their value from DONE until the next accepted start.
REQ-023 The module SHALL ignore start while busy=1.
REQ-024 flush SHALL force IDLE in any state on the next edge without asserting done; flush and start together in IDLE SHALL resolve in favour of flush.
REQ-025 Arithmetic boundary behaviour SHALL be: LSL 32 gives 0 with C=operand[0]; LSL/LSR 33 and above gives 0 with C=0; LSR 32 gives 0 with C=operand[31]; ASR of 32 or more gives all sign bits with C=operand[31].

Reset
REQ-026 While rst=1, the module SHALL hold state=IDLE, busy=0, done=0, result=0, carry_out=0 and remaining=0, independent of clk.
REQ-027 The module SHALL abandon any shift in progress when rst is asserted, and SHALL NOT assert done after rst is released until a new start is accepted.

Structure
REQ-028 A shared package SHALL hold the shift-type enum (LSL, LSR, ASR, ROR), the state enum and the STEP_DEFAULT constant.
REQ-029 One combinational sub-module, shift_step, SHALL perform a single shift of 0..STEP positions and return the new value and carry; shift_seq SHALL instantiate it once.

Verification
REQ-030 The bench SHALL cover: LSL operand=0x0000_0001, amount=4, STEP=8 -> done on cycle 2, result=0x0000_0010, C=0.
REQ-031 The bench SHALL cover: LSR operand=0x8000_0001, amount=32 -> done on cycle 5, result=0, C=1; the same with amount=40 -> result=0, C=0.
REQ-032 The bench SHALL cover: ASR operand=0x8000_0000, amount=200 -> result=0xFFFF_FFFF, C=1; ROR operand=0x0000_00F1, amount=4 -> result=0x1000_000F, C=0.
REQ-033 The bench SHALL cover: amount=0 with carry_in=1 -> done on cycle 1, result=operand, C=1; ROR with amount=32 and operand=0x8000_0000 -> C=1.
REQ-034 The bench SHALL cover: start pulsed again mid-SHIFT -> ignored, with only one done pulse.
REQ-035 The bench SHALL cover: flush asserted on the 2nd SHIFT cycle -> IDLE on the next edge, no done; rst asserted mid-SHIFT -> outputs at reset values immediately.
